// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and defaults for the system-bus round-robin arbiter and its picker.
// Master channel numbers give each SoC bus master a fixed request/grant bit.
package bus_rr_arbiter_pkg;

    localparam int unsigned NumMastersDef = 4;
    localparam int unsigned MaxHoldDef    = 16;

    // Bus master channel assignments within the request/grant vectors
    localparam int unsigned BusMasterChCpuInstr = 0;
    localparam int unsigned BusMasterChCpuData  = 1;
    localparam int unsigned BusMasterChDma      = 2;
    localparam int unsigned BusMasterChSpare    = 3;

    typedef enum logic {
        ArbIdle  = 1'b0,
        ArbOwned = 1'b1
    } arb_state_e;

    // Index following idx in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first requester at or after i_start, wrapping,
// skipping any entry set in i_excl.
module bus_rr_arbiter_rr_pick
    import bus_rr_arbiter_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    input  logic [N-1:0]     i_excl,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    logic [N-1:0]     w_cand;
    logic [IDX_W-1:0] w_pos;

    assign w_cand = i_req & ~i_excl;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = i_start;
        for (int unsigned k = 0; k < N; k++) begin
            if (!o_found && w_cand[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end
            w_pos = IDX_W'(rr_next(32'(w_pos), N));
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin system-bus arbiter with registered one-hot/encoded grant, a hold limit
// that forces rotation when others wait, and a per-owner lock that suppresses it.
module bus_rr_arbiter
    import bus_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = NumMastersDef,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned MAX_HOLD    = MaxHoldDef,
    parameter int unsigned CNT_W       = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] lock,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   grant_vld,
    output logic                   preempt
);

    arb_state_e             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [IDX_W-1:0]       r_grant_idx;
    logic [IDX_W-1:0]       r_last_owner;
    logic [CNT_W-1:0]       r_hold_cnt;
    logic                   r_preempt;

    logic [IDX_W-1:0]       w_start;
    logic [NUM_MASTERS-1:0] w_excl;
    logic                   w_found;
    logic [IDX_W-1:0]       w_pick_idx;
    logic [NUM_MASTERS-1:0] w_pick_grant;
    logic                   w_owner_req;
    logic                   w_owner_lock;
    logic                   w_hold_sat;

    assign w_start      = IDX_W'(rr_next(32'(r_last_owner), NUM_MASTERS));
    // While owned, r_grant is the owner's one-hot bit; the owner never re-wins its own search
    assign w_excl       = (r_state == ArbOwned) ? r_grant : '0;
    assign w_pick_grant = NUM_MASTERS'(1) << w_pick_idx;
    assign w_owner_req  = |(req & r_grant);
    assign w_owner_lock = |(lock & r_grant);
    assign w_hold_sat   = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

    bus_rr_arbiter_rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req   (req),
        .i_start (w_start),
        .i_excl  (w_excl),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ArbIdle;
            r_grant      <= '0;
            r_grant_idx  <= '0;
            r_last_owner <= IDX_W'(NUM_MASTERS - 1);
            r_hold_cnt   <= '0;
            r_preempt    <= 1'b0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                ArbIdle: begin
                    if (w_found) begin
                        r_state      <= ArbOwned;
                        r_grant      <= w_pick_grant;
                        r_grant_idx  <= w_pick_idx;
                        r_last_owner <= w_pick_idx;
                        r_hold_cnt   <= '0;
                    end
                end
                ArbOwned: begin
                    if (!w_owner_req) begin
                        // Owner released; a drop outranks any pending forced rotation
                        if (w_found) begin
                            r_grant      <= w_pick_grant;
                            r_grant_idx  <= w_pick_idx;
                            r_last_owner <= w_pick_idx;
                            r_hold_cnt   <= '0;
                        end else begin
                            r_state    <= ArbIdle;
                            r_grant    <= '0;
                            r_hold_cnt <= '0;
                        end
                    end else if (w_hold_sat && w_found && !w_owner_lock) begin
                        r_grant      <= w_pick_grant;
                        r_grant_idx  <= w_pick_idx;
                        r_last_owner <= w_pick_idx;
                        r_hold_cnt   <= '0;
                        r_preempt    <= 1'b1;
                    end else if (!w_hold_sat) begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_grant_idx;
    assign grant_vld = (r_state == ArbOwned);
    assign preempt   = r_preempt;

endmodule
